// File: rtl/hold_1_mon.sv
// hold_1_mon: downstream monitor for the hold_1 FSM outputs.
//
// Measures each g_win window length in clk cycles, checks that exactly one
// f_tgl toggle belongs to the window (allowing a late toggle up to TGL_TO
// cycles after g falls), and emits one report per window through a
// single-entry valid/ready buffer. Also keeps a wrapping count of good frames
// and sticky status flags (report overflow, stray toggle while idle).
//
// Optional build macro HOLD_1_MON_TS_EN adds a free-running cycle counter and
// an rpt_ts output that captures the counter in each report's finish cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   g_win, f_tgl          window level / toggle-per-frame level from upstream
//   clr                   synchronous clear of frame_cnt, ovf, stray
//   rpt_valid/rpt_ready   report buffer handshake
//   rpt_len, rpt_err      buffered window length and error code
//                         (0 OK, 1 NO_TGL, 2 SHORT, 3 MULTI)
//   rpt_ts                finish-cycle timestamp (HOLD_1_MON_TS_EN only)
//   frame_cnt             completed windows with error code OK (wraps)
//   busy                  monitor is inside a window or waiting for a toggle
//   ovf, stray            sticky status flags
module hold_1_mon #(
    parameter int LEN_W   = 8,
    parameter int CNT_W   = 16,
    parameter int TGL_TO  = 4,
    parameter int MIN_LEN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             g_win,
    input  logic             f_tgl,
    input  logic             clr,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [LEN_W-1:0] rpt_len,
    output logic [1:0]       rpt_err,
`ifdef HOLD_1_MON_TS_EN
    output logic [CNT_W-1:0] rpt_ts,
`endif
    output logic [CNT_W-1:0] frame_cnt,
    output logic             busy,
    output logic             ovf,
    output logic             stray
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WIN      = 2'd1,
        WAIT_TGL = 2'd2
    } state_t;

    localparam logic [1:0]       ERR_OK     = 2'd0;
    localparam logic [1:0]       ERR_NO_TGL = 2'd1;
    localparam logic [1:0]       ERR_SHORT  = 2'd2;
    localparam logic [1:0]       ERR_MULTI  = 2'd3;
    localparam logic [7:0]       TO_LAST    = 8'(TGL_TO - 1);
    localparam logic [LEN_W-1:0] MIN_LEN_L  = LEN_W'(MIN_LEN);

    // Window length saturates at all-ones instead of wrapping.
    function automatic logic [LEN_W-1:0] len_inc(input logic [LEN_W-1:0] l);
        return (l == '1) ? l : l + 1'b1;
    endfunction

    // Toggle count only needs to distinguish 0, 1 and "more than one".
    function automatic logic [1:0] tc_add(input logic [1:0] t, input logic inc);
        return (inc && t != 2'd2) ? t + 2'd1 : t;
    endfunction

    function automatic logic [1:0] err_code(input logic no_tgl, input logic [1:0] t,
                                            input logic [LEN_W-1:0] l);
        if (no_tgl)    return ERR_NO_TGL;
        if (t == 2'd2) return ERR_MULTI;
        if (l < MIN_LEN_L) return ERR_SHORT;
        return ERR_OK;
    endfunction

    state_t           state_q, state_d;
    logic             g_q, f_q;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       tc_q, tc_d, tc_sum;
    logic [7:0]       to_q, to_d;

    logic             rise, tgl;
    logic             fin, fin_no_tgl, stray_evt, load;
    logic [1:0]       fin_tc, fin_err;
    logic [LEN_W-1:0] fin_len;

    assign rise = g_win & ~g_q;
    assign tgl  = f_tgl ^ f_q;
    assign busy = (state_q == WIN) || (state_q == WAIT_TGL);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        tc_d       = tc_q;
        to_d       = to_q;
        tc_sum     = tc_add(tc_q, tgl);
        fin        = 1'b0;
        fin_no_tgl = 1'b0;
        fin_tc     = tc_q;
        fin_len    = len_q;
        stray_evt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = WIN;
                    len_d   = LEN_W'(1);
                    tc_d    = {1'b0, tgl};
                end else if (tgl) begin
                    stray_evt = 1'b1;
                end
            end
            WIN: begin
                tc_d = tc_sum;
                if (g_win) begin
                    len_d = len_inc(len_q);
                end else if (tc_sum != 2'd0) begin
                    // Toggle already seen (usually coincident with the fall).
                    fin     = 1'b1;
                    fin_tc  = tc_sum;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_TGL;
                    to_d    = 8'd0;
                end
            end
            WAIT_TGL: begin
                if (rise) begin
                    // Close the untoggled window and open the next one at once
                    // so a back-to-back rise is never lost.
                    fin        = 1'b1;
                    fin_no_tgl = 1'b1;
                    state_d    = WIN;
                    len_d      = LEN_W'(1);
                    tc_d       = {1'b0, tgl};
                end else if (tgl) begin
                    fin     = 1'b1;
                    fin_tc  = 2'd1;
                    tc_d    = 2'd1;
                    state_d = IDLE;
                end else if (to_q == TO_LAST) begin
                    fin        = 1'b1;
                    fin_no_tgl = 1'b1;
                    state_d    = IDLE;
                end else begin
                    to_d = to_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        fin_err = err_code(fin_no_tgl, fin_tc, fin_len);
    end

    // A report can enter the buffer when it is empty or being drained now.
    assign load = fin & (~rpt_valid | rpt_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_q     <= 1'b0;
            f_q     <= 1'b0;
            len_q   <= '0;
            tc_q    <= 2'd0;
            to_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            g_q     <= g_win;
            f_q     <= f_tgl;
            len_q   <= len_d;
            tc_q    <= tc_d;
            to_q    <= to_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_valid <= 1'b0;
            rpt_len   <= '0;
            rpt_err   <= 2'd0;
        end else if (load) begin
            rpt_valid <= 1'b1;
            rpt_len   <= fin_len;
            rpt_err   <= fin_err;
        end else if (rpt_ready) begin
            rpt_valid <= 1'b0;
        end
    end

    // clr takes priority over any event arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            ovf       <= 1'b0;
            stray     <= 1'b0;
        end else if (clr) begin
            frame_cnt <= '0;
            ovf       <= 1'b0;
            stray     <= 1'b0;
        end else begin
            if (fin && fin_err == ERR_OK) frame_cnt <= frame_cnt + 1'b1;
            if (fin && !load)             ovf       <= 1'b1;
            if (stray_evt)                stray     <= 1'b1;
        end
    end

`ifdef HOLD_1_MON_TS_EN
    logic [CNT_W-1:0] ts_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= '0;
            rpt_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (load) rpt_ts <= ts_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_hold_1_mon.sv
// Testbench for hold_1_mon: directed scenarios plus a randomized phase, all
// compared each cycle against a window-level behavioural model.
module tb_hold_1_mon;

    localparam int LEN_W   = 8;
    localparam int CNT_W   = 16;
    localparam int TGL_TO  = 4;
    localparam int MIN_LEN = 2;
    localparam int LEN_MAX = (1 << LEN_W) - 1;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             g_win = 1'b0;
    logic             f_tgl = 1'b0;
    logic             clr = 1'b0;
    logic             rpt_ready = 1'b0;
    logic             rpt_valid;
    logic [LEN_W-1:0] rpt_len;
    logic [1:0]       rpt_err;
    logic [CNT_W-1:0] frame_cnt;
    logic             busy, ovf, stray;
`ifdef HOLD_1_MON_TS_EN
    logic [CNT_W-1:0] rpt_ts;
`endif

    hold_1_mon #(
        .LEN_W(LEN_W), .CNT_W(CNT_W), .TGL_TO(TGL_TO), .MIN_LEN(MIN_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .g_win(g_win), .f_tgl(f_tgl), .clr(clr),
        .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_len(rpt_len),
        .rpt_err(rpt_err),
`ifdef HOLD_1_MON_TS_EN
        .rpt_ts(rpt_ts),
`endif
        .frame_cnt(frame_cnt), .busy(busy), .ovf(ovf), .stray(stray)
    );

    always #5 clk = ~clk;

    int    n_chk = 0;
    int    n_pass = 0;
    string phase = "init";
    bit    f_lvl = 1'b0;

    // ---------------- behavioural model (window level) ----------------
    bit m_gq, m_fq;           // previous g / f levels
    bit m_in_win, m_waiting;  // inside window / waiting for late toggle
    int m_len, m_ntg, m_wel;  // raw length, raw toggle count, wait cycles elapsed
    bit m_v;                  // buffered report
    int m_rlen, m_rerr, m_rts;
    int m_cnt, m_cyc;
    bit m_ovf, m_stray;

    task automatic model_reset();
        m_gq = 0; m_fq = 0; m_in_win = 0; m_waiting = 0;
        m_len = 0; m_ntg = 0; m_wel = 0;
        m_v = 0; m_rlen = 0; m_rerr = 0; m_rts = 0;
        m_cnt = 0; m_cyc = 0; m_ovf = 0; m_stray = 0;
    endtask

    task automatic model_step(input bit g, input bit f, input bit rdy, input bit c);
        bit rise, tg, fin, no_tgl, stray_evt, load;
        int flen, fntg, err;
        rise = g && !m_gq;
        tg = (f != m_fq);
        fin = 0; no_tgl = 0; stray_evt = 0;
        flen = m_len; fntg = m_ntg;
        if (m_in_win) begin
            m_ntg += int'(tg);
            if (g) m_len++;
            else begin
                m_in_win = 0;
                if (m_ntg > 0) begin fin = 1; flen = m_len; fntg = m_ntg; end
                else begin m_waiting = 1; m_wel = 0; end
            end
        end else if (m_waiting) begin
            if (rise) begin
                fin = 1; no_tgl = 1; flen = m_len; m_waiting = 0;
                m_in_win = 1; m_len = 1; m_ntg = int'(tg);
            end else if (tg) begin
                fin = 1; flen = m_len; fntg = 1; m_waiting = 0;
            end else if (m_wel + 1 == TGL_TO) begin
                fin = 1; no_tgl = 1; flen = m_len; m_waiting = 0;
            end else m_wel++;
        end else if (rise) begin
            m_in_win = 1; m_len = 1; m_ntg = int'(tg);
        end else if (tg) stray_evt = 1;

        if (flen > LEN_MAX) flen = LEN_MAX;
        if (no_tgl) err = 1;
        else if (fntg >= 2) err = 3;
        else if (flen < MIN_LEN) err = 2;
        else err = 0;

        load = fin && (!m_v || rdy);
        if (c) begin
            m_cnt = 0; m_ovf = 0; m_stray = 0;
        end else begin
            if (fin && err == 0) m_cnt = (m_cnt + 1) % CNT_MOD;
            if (fin && !load) m_ovf = 1;
            if (stray_evt) m_stray = 1;
        end
        if (load) begin
            m_v = 1; m_rlen = flen; m_rerr = err; m_rts = m_cyc;
        end else if (m_v && rdy) m_v = 0;
        m_cyc = (m_cyc + 1) % CNT_MOD;
        m_gq = g; m_fq = f;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s/%s: observed %0d, expected %0d", phase, tag, obs, exp);
    endtask

    task automatic check_all();
        check("rpt_valid", 32'(rpt_valid), 32'(m_v));
        if (m_v) begin
            check("rpt_len", 32'(rpt_len), 32'(m_rlen));
            check("rpt_err", 32'(rpt_err), 32'(m_rerr));
`ifdef HOLD_1_MON_TS_EN
            check("rpt_ts", 32'(rpt_ts), 32'(m_rts));
`endif
        end
        check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("stray", 32'(stray), 32'(m_stray));
        check("busy", 32'(busy), 32'(m_in_win || m_waiting));
    endtask

    task automatic check_zero();
        check("rst_valid", 32'(rpt_valid), 32'd0);
        check("rst_len", 32'(rpt_len), 32'd0);
        check("rst_err", 32'(rpt_err), 32'd0);
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_stray", 32'(stray), 32'd0);
`ifdef HOLD_1_MON_TS_EN
        check("rst_ts", 32'(rpt_ts), 32'd0);
`endif
    endtask

    // One clock cycle: apply inputs, advance model, compare after the edge.
    task automatic step(input bit g, input bit do_tgl, input bit rdy, input bit c);
        if (do_tgl) f_lvl = ~f_lvl;
        g_win = g; f_tgl = f_lvl; rpt_ready = rdy; clr = c;
        model_step(g, f_lvl, rdy, c);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset(input bit async_chk);
        rst_n = 1'b0;
        g_win = 0; f_tgl = 0; f_lvl = 0; clr = 0; rpt_ready = 0;
        if (async_chk) begin
            #1;
            check_zero();
        end
        @(posedge clk);
        #1;
        check_zero();
        model_reset();
        rst_n = 1'b1;
    endtask

    // hold_1-style window: g high for hi cycles, toggle on the falling cycle.
    task automatic hold_win(input int hi, input bit rdy);
        for (int i = 0; i < hi; i++) step(1, 0, rdy, 0);
        step(0, 1, rdy, 0);
    endtask

    initial begin
        model_reset();
        do_reset(0);

        phase = "hold1";
        for (int w = 0; w < 5; w++) hold_win(7, 1);
        check("t1_cnt", 32'(frame_cnt), 32'd5);
        check("t1_len", 32'(rpt_len), 32'd7);
        step(0, 0, 1, 0);

        phase = "late_tgl";
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        step(0, 0, 1, 0);
        phase = "no_tgl";
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
        check("t2_err", 32'(rpt_err), 32'd1);
        step(0, 0, 1, 0);

        phase = "multi_short";
        step(1, 0, 1, 0); step(1, 1, 1, 0); step(1, 0, 1, 0);
        step(1, 1, 1, 0); step(1, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        step(0, 1, 1, 0);
        check("t3_err", 32'(rpt_err), 32'd2);
        step(0, 0, 1, 0);

        phase = "backpressure";
        for (int w = 0; w < 3; w++) hold_win(7, 0);
        check("t4_ovf", 32'(ovf), 32'd1);
        step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        phase = "stray_clr";
        step(0, 1, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        check("t5_clr_cnt", 32'(frame_cnt), 32'd0);
        phase = "mid_reset";
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
        do_reset(1);
        step(0, 0, 1, 0);
        hold_win(7, 1);
        step(0, 0, 1, 0);

        phase = "saturate";
        hold_win(300, 1);
        check("t6_len", 32'(rpt_len), 32'd255);
        step(0, 0, 1, 0);

        phase = "random";
        for (int w = 0; w < 150; w++) begin
            int hi, lo, tpos;
            hi = $urandom_range(1, 12);
            lo = $urandom_range(1, 8);
            tpos = $urandom_range(0, lo + 1);   // beyond lo means no toggle
            for (int i = 0; i < hi; i++)
                step(1, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 49) == 0));
            for (int i = 0; i < lo; i++)
                step(0, (i == tpos), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 49) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
